// File: rtl/pool_window_gen.sv
// -----------------------------------------------------------------------------
// pool_window_gen
//
// Turns a raster-scan pixel stream into non-overlapping stride-2 2x2 windows
// for the average-pooling stage. One image row is held in a line buffer. The
// next (odd) row pairs with it to form windows.
//
// Ports
//   clk         : single clock, rising edge
//   rstn        : asynchronous active-low reset
//   valid       : input_act carries the next raster pixel this cycle
//   input_act   : one pixel, channel i at [(i+1)*NBITS-1 : i*NBITS]
//   output_act  : registered window, channel i at [(i+1)*4*NBITS-1 : i*4*NBITS],
//                 word0=TL, word1=TR, word2=BL, word3=BR within each slice
//   ready       : one-cycle pulse, output_act holds a new window
//   frame_done  : one-cycle pulse alongside the last window of a frame
// -----------------------------------------------------------------------------
module pool_window_gen #(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = 2,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     valid,
  input  logic [NBITS*NFMAPS-1:0]                  input_act,
  output logic [NBITS*KER_SIZE*KER_SIZE*NFMAPS-1:0] output_act,
  output logic                                     ready,
  output logic                                     frame_done
);

  localparam int PIX_W = NBITS * NFMAPS;
  localparam int WIN_W = NBITS * KER_SIZE * KER_SIZE * NFMAPS;
  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // Elaboration-time parameter guards.
  generate
    if (KER_SIZE != 2) begin : g_bad_ker
      $error("pool_window_gen: only KER_SIZE=2 is supported");
    end
    if ((IMG_W < 2) || (IMG_W % 2 != 0)) begin : g_bad_w
      $error("pool_window_gen: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_h
      $error("pool_window_gen: IMG_H must be even and >= 2");
    end
  endgenerate

  logic [PIX_W-1:0] linebuf [IMG_W];
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_left;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] bl_reg;
  logic [PIX_W-1:0] tl_pix;
  logic [PIX_W-1:0] tr_pix;
  logic [WIN_W-1:0] window;
  logic             fill_row;

  // Even rows fill the line buffer, odd rows pair with it.
  assign fill_row = ~row[0];
  // Left column of the current pair (col is odd when a window launches).
  assign col_left = col & ~COL_W'(1);
  assign tl_pix   = linebuf[col_left];
  assign tr_pix   = linebuf[col];

  // Interleave the four pixels channel by channel into the pooling layout.
  always_comb begin
    // NOTE: full default first so no path through this block leaves window
    // unassigned; that keeps it purely combinational (no latch).
    window = '0;
    for (int i = 0; i < NFMAPS; i++) begin
      window[(i*4 + 0)*NBITS +: NBITS] = tl_pix[i*NBITS +: NBITS];
      window[(i*4 + 1)*NBITS +: NBITS] = tr_pix[i*NBITS +: NBITS];
      window[(i*4 + 2)*NBITS +: NBITS] = bl_reg[i*NBITS +: NBITS];
      window[(i*4 + 3)*NBITS +: NBITS] = input_act[i*NBITS +: NBITS];
    end
  end

  // NOTE: the line buffer has no reset; every entry is rewritten by a FILL row
  // before any PAIR row reads it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (valid && fill_row) begin
      linebuf[col] <= input_act;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col        <= '0;
      row        <= '0;
      bl_reg     <= '0;
      output_act <= '0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ready      <= 1'b0;
      frame_done <= 1'b0;
      if (valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end

        if (!fill_row) begin
          if (!col[0]) begin
            bl_reg <= input_act;
          end else begin
            output_act <= window;
            ready      <= 1'b1;
            frame_done <= (row == ROW_LAST) && (col == COL_LAST);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pool_window_gen
//
// Randomised self-checking bench for pool_window_gen (NBITS=8, NFMAPS=2,
// 4x4 image). A raster-index image model predicts ready/frame_done/output_act
// each cycle; literal window tables pin the model to known answers.
// -----------------------------------------------------------------------------
module tb_pool_window_gen;

  localparam int NB   = 8;
  localparam int NF   = 2;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int PW   = NB * NF;
  localparam int OW   = NB * 4 * NF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid = 1'b0;
  logic [PW-1:0] input_act = '0;
  logic [OW-1:0] output_act;
  logic          ready;
  logic          frame_done;

  pool_window_gen #(
    .NBITS(NB), .NFMAPS(NF), .KER_SIZE(2), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .valid(valid),
    .input_act(input_act),
    .output_act(output_act),
    .ready(ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] img [NPIX];
  int            idx = 0;
  int            mr, mc;
  logic [OW-1:0] m_out = '0;
  logic          m_ready = 1'b0;
  logic          m_fd = 1'b0;

  function automatic logic [OW-1:0] pack4(input logic [PW-1:0] tl, input logic [PW-1:0] tr,
                                          input logic [PW-1:0] bl, input logic [PW-1:0] br);
    logic [PW-1:0] px [4];
    logic [OW-1:0] v;
    px = '{tl, tr, bl, br};
    v  = '0;
    for (int ch = 0; ch < NF; ch++)
      for (int w = 0; w < 4; w++)
        v[(ch*4 + w)*NB +: NB] = px[w][ch*NB +: NB];
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx = 0; m_out = '0; m_ready = 1'b0; m_fd = 1'b0;
    end else begin
      m_ready = 1'b0;
      m_fd    = 1'b0;
      if (valid) begin
        mr = idx / W;
        mc = idx % W;
        img[idx] = input_act;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
          m_out   = pack4(img[idx-W-1], img[idx-W], img[idx-1], img[idx]);
          m_ready = 1'b1;
          m_fd    = (idx == NPIX - 1);
        end
        idx = (idx + 1) % NPIX;
      end
    end
  end

  // ---------------- per-cycle compare and capture ----------------
  logic [OW-1:0] cap [$];
  int rdy_cnt = 0;
  int fd_cnt  = 0;

  always @(negedge clk) begin
    if (rstn) begin
      check("ready", 64'(ready), 64'(m_ready));
      check("frame_done", 64'(frame_done), 64'(m_fd));
      check("output_act", output_act, m_out);
      if (ready) begin
        cap.push_back(output_act);
        rdy_cnt++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    cap.delete();
    rdy_cnt = 0;
    fd_cnt  = 0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int gap);
    valid     = 1'b1;
    input_act = {b, a};
    @(posedge clk); #1;
    valid     = 1'b0;
    input_act = PW'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int off0, input int off1, input int maxgap);
    for (int p = 0; p < NPIX; p++)
      send(8'(off0 + p), 8'(off1 + p), int'($urandom_range(0, maxgap)));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Literal window: fmap0 words base0+p*, fmap1 words base1+p*.
  function automatic logic [63:0] lit(input int p0, input int p1, input int p2, input int p3,
                                      input int b0, input int b1);
    return {8'(b1+p3), 8'(b1+p2), 8'(b1+p1), 8'(b1+p0),
            8'(b0+p3), 8'(b0+p2), 8'(b0+p1), 8'(b0+p0)};
  endfunction

  int exp_tl [4] = '{0, 2, 8, 10};
  int exp_avg[4] = '{2, 4, 10, 12};

  task automatic check_frame(input string tag, input int first, input int b0, input int b1);
    logic [63:0] got;
    for (int k = 0; k < 4; k++) begin
      got = (first + k < cap.size()) ? 64'(cap[first+k]) : 'x;
      check($sformatf("%s_win%0d", tag, k), got,
            lit(exp_tl[k], exp_tl[k]+1, exp_tl[k]+4, exp_tl[k]+5, b0, b1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sum;
    logic [63:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_output_act", output_act, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Continuous frame
    clear_log();
    send_frame(0, 100, 0);
    check("cont_n_windows", 64'(rdy_cnt), 64'd4);
    check("cont_n_frame_done", 64'(fd_cnt), 64'd1);
    check_frame("cont", 0, 0, 100);
    for (int k = 0; k < 4; k++) begin
      w   = (k < cap.size()) ? 64'(cap[k]) : '0;
      sum = int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16]) + int'(w[31:24]);
      check($sformatf("cont_avg%0d", k), 64'(sum / 4), 64'(exp_avg[k]));
    end

    // Random valid gaps
    clear_log();
    send_frame(0, 100, 3);
    check("gaps_n_windows", 64'(rdy_cnt), 64'd4);
    check("gaps_n_frame_done", 64'(fd_cnt), 64'd1);
    check_frame("gaps", 0, 0, 100);

    // Back-to-back frames
    clear_log();
    for (int p = 0; p < NPIX; p++) send(8'(p), 8'(100 + p), 0);
    send_frame(16, 116, 0);
    check("b2b_n_windows", 64'(rdy_cnt), 64'd8);
    check("b2b_n_frame_done", 64'(fd_cnt), 64'd2);
    check_frame("b2b_f1", 0, 0, 100);
    check("b2b_f2_win0", (cap.size() > 4) ? 64'(cap[4]) : 'x, lit(16, 17, 20, 21, 0, 100));

    // Mid-frame reset after pixel 6
    clear_log();
    for (int p = 0; p <= 6; p++) send(8'(p), 8'(100 + p), 0);
    check("pre_rst_window", output_act, lit(0, 1, 4, 5, 0, 100));
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_output_act", output_act, 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_log();
    send_frame(0, 100, 2);
    check("midrst_n_windows", 64'(rdy_cnt), 64'd4);
    check_frame("midrst", 0, 0, 100);

    // Signed-looking data: fmap0 = 0x80+p
    clear_log();
    send_frame(128, 100, 1);
    check("signed_n_windows", 64'(rdy_cnt), 64'd4);
    check_frame("signed", 0, 128, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
# pool_window_gen

Window generator that feeds the 2x2 average-pooling stage. It accepts a raster-scan stream of activation pixels, one pixel (all NFMAPS channels) per valid cycle. It buffers one image row and emits non-overlapping stride-2 2x2 windows. Output windows are packed in exactly the layout the pooling stage consumes, so the two blocks connect port-to-port (`ready` → `valid`, `output_act` → `input_act`).

## Interface
- `NBITS`, 32, bits per activation word.
- `NFMAPS`, 32, channels per pixel.
- `KER_SIZE`, 2, window edge. Only 2 is supported; elaboration fails on any other value.
- `IMG_W`, 8, pixels per row. Must be even and ≥ 2.
- `IMG_H`, 8, rows per frame. Must be even and ≥ 2.
- `clk` in 1: single clock, all state on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `valid` in 1: `input_act` carries the next raster pixel this cycle.
- `input_act` in NBITS*NFMAPS: channel i occupies `[(i+1)*NBITS-1 : i*NBITS]`.
- `output_act` out NBITS*KER_SIZE*KER_SIZE*NFMAPS: window data.
  - Channel i occupies slice `[(i+1)*4*NBITS-1 : i*4*NBITS]`.
  - Within the slice, word0 = top-left, word1 = top-right, word2 = bottom-left, word3 = bottom-right.
- `ready` out 1: one-cycle pulse; `output_act` holds a new window.
- `frame_done` out 1: one-cycle pulse coincident with the last window of a frame.

## Operation
- Counters:
  - `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on cycles with `valid`=1.
  - `col` wraps to 0 after IMG_W-1 and increments `row`.
  - `row` wraps to 0 after IMG_H-1, i.e. at the end of the frame.
- State is `row[0]`:
  - FILL (even row): each accepted pixel is written to `linebuf[col]`. Depth is IMG_W entries of NBITS*NFMAPS. No output.
  - PAIR (odd row), even `col`: the pixel is captured in `bl_reg`.
  - PAIR (odd row), odd `col`: a window is launched from `linebuf[col-1]`, `linebuf[col]`, `bl_reg`, and the current pixel, as TL/TR/BL/BR respectively.
- The line buffer is not written in PAIR rows. Its contents are overwritten by the next FILL row.
- Window data is copied bit-exact; no arithmetic, no sign handling.
- Windows per frame: (IMG_W/2)*(IMG_H/2), emitted in raster order of the pooled grid.
- No backpressure: the downstream stage must accept every `ready` pulse.
- Valid gaps (`valid`=0 for any number of cycles, at any position) change no state except clearing `ready`/`frame_done`.
- Back-to-back frames: the pixel after the last pixel of a frame is row 0, col 0 of the next frame, with no idle cycle required.

## Timing
- Reset (`rstn`=0, asynchronous assert):
  - `col`=0, `row`=0.
  - `bl_reg`=0, `output_act`=0, `ready`=0, `frame_done`=0.
  - Line buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The first pixel after release is treated as row 0, col 0.
- Latency: `ready` rises on the clock edge after the cycle in which the bottom-right pixel is accepted, i.e. 1 cycle.
- `output_act` is registered. It holds the last window until the next window launches and never changes while `ready`=0, except at reset.
- `ready` and `frame_done` are high for exactly one cycle per event. They can be high in consecutive cycles only if windows complete on consecutive cycles, which cannot occur for KER_SIZE=2.
- `frame_done` is high in the same cycle as `ready` for the window whose BR pixel is at (IMG_H-1, IMG_W-1).
- A line-buffer read and write never target the same entry in the same cycle: writes occur only in FILL rows, reads only in PAIR rows.

## Test plan
Common setup: `NBITS`=8, `NFMAPS`=2, `IMG_W`=4, `IMG_H`=4. Pixel p (raster index 0..15) drives fmap0=p and fmap1=100+p.

- **Continuous frame.** Drive 16 pixels on consecutive `valid` cycles.
  - Exactly 4 `ready` pulses, 1 cycle after pixels 5, 7, 13, 15.
  - fmap0 words (w0..w3): {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
  - fmap1 words: the fmap0 values +100 in each case.
  - `frame_done` is high only with the 4th pulse.
- **Random valid gaps.** Same frame with 0–3 idle cycles between pixels.
  - Identical window data and order.
  - Each `ready` pulse lands 1 cycle after its BR pixel.
  - `output_act` is stable between pulses.
- **Back-to-back frames.** Send two frames; frame 2 uses values p+16.
  - 8 windows total; the first frame-2 window is fmap0 {16,17,20,21}.
  - `frame_done` pulses twice.
- **Mid-frame reset.** Assert `rstn`=0 asynchronously after pixel 6, then release and send a fresh 16-pixel frame.
  - Outputs go to 0 immediately on reset assertion.
  - No window is emitted from the stale pixels.
  - The first window is {0,1,4,5}.
- **Chained with the pooling stage.** Connect to the 2x2 average-pool block.
  - For the continuous frame, fmap0 averages are 2, 4, 10, 12.
  - The pool's `ready` follows each window's `ready` by 1 cycle.
- **Signed data.** Drive fmap0 pixel values 0x80..0x8F.
  - Windows reproduce the bytes bit-exact; no sign extension or alteration in `output_act`.
